// File: rtl/fsm_pkg.sv
// Shared encodings for the layer-sequencing controller.
// Imported by the controller, the datapath and the bench.
package fsm_pkg;

  localparam int unsigned FSM_BITS = 5;

  typedef logic [FSM_BITS-1:0] fsm_state_t;

  localparam fsm_state_t IDLE        = 5'd0;
  localparam fsm_state_t FIRST_LOAD  = 5'd1;
  localparam fsm_state_t CPB_0       = 5'd2;
  localparam fsm_state_t CPB_1       = 5'd3;
  localparam fsm_state_t CPB_2       = 5'd4;
  localparam fsm_state_t CPB_LOADNEW = 5'd5;
  localparam fsm_state_t CPB_3       = 5'd6;
  localparam fsm_state_t CPB_4       = 5'd7;

  // Codes above CPB_4 are never produced by the decoder and are recovered to IDLE.
  function automatic logic is_legal_state(input fsm_state_t s);
    return s <= CPB_4;
  endfunction

endpackage

// File: rtl/fsm_ctrl.sv
// Layer-sequencing controller: steps the compute pipeline through its phases on
// one-cycle phase-done flags, with a one-deep pending-start latch for runs requested mid-run.
module fsm_ctrl
  import fsm_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                auto,
  input  logic                start,
  input  logic                man_reset,
  input  logic                flag_firstload_end,
  input  logic                flag_cpb0_end,
  input  logic                flag_cpb1_end,
  input  logic                flag_cpb2_end,
  input  logic                flag_cpbldnew_end,
  input  logic                flag_cpb3_end,
  input  logic                flag_cpb4_end,
  output logic                busy,
  output logic [FSM_BITS-1:0] out_current_state,
  output logic [FSM_BITS-1:0] out_prev_state
);

  fsm_state_t state_q, state_d;
  fsm_state_t prev_q, prev_d;
  logic       pending_q, pending_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      prev_q    <= IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
    end
  end

  // Only the flag owned by the current state is examined, so a held flag advances one step.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (man_reset) begin
      state_d   = IDLE;
      pending_d = 1'b0;
    end else if (state_q == IDLE) begin
      if (start || pending_q) begin
        state_d   = FIRST_LOAD;
        pending_d = 1'b0;
      end
    end else begin
      if (start) begin
        pending_d = 1'b1;
      end
      if (!is_legal_state(state_q)) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          FIRST_LOAD:  if (flag_firstload_end) state_d = CPB_0;
          CPB_0:       if (flag_cpb0_end)      state_d = CPB_1;
          CPB_1:       if (flag_cpb1_end)      state_d = CPB_2;
          CPB_2:       if (flag_cpb2_end)      state_d = CPB_LOADNEW;
          CPB_LOADNEW: if (flag_cpbldnew_end)  state_d = CPB_3;
          CPB_3:       if (flag_cpb3_end)      state_d = CPB_4;
          CPB_4:       if (flag_cpb4_end)      state_d = auto ? FIRST_LOAD : IDLE;
          default:     state_d = IDLE;
        endcase
      end
    end
    prev_d = (state_d != state_q) ? state_q : prev_q;
  end

  always_comb begin
    busy              = (state_q != IDLE);
    out_current_state = state_q;
    out_prev_state    = prev_q;
  end

endmodule

// File: tb/tb_fsm_ctrl.sv
// Self-checking bench for fsm_ctrl: directed scenarios plus randomized stimulus
// compared every cycle against a phase-index reference model.
module tb_fsm_ctrl;
  import fsm_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic auto = 1'b0, start = 1'b0, man_reset = 1'b0;
  logic [7:1] flags = '0;  // flags[p] is the done flag of phase p
  logic busy;
  logic [FSM_BITS-1:0] cur_state, prev_state;

  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;
  int busy_drops = 0;

  // Reference model: phase number 0 (idle) .. 7, plus pending-run flag and previous phase.
  int  m_phase = 0;
  int  m_prev = 0;
  bit  m_pend = 0;

  fsm_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .auto              (auto),
    .start             (start),
    .man_reset         (man_reset),
    .flag_firstload_end(flags[1]),
    .flag_cpb0_end     (flags[2]),
    .flag_cpb1_end     (flags[3]),
    .flag_cpb2_end     (flags[4]),
    .flag_cpbldnew_end (flags[5]),
    .flag_cpb3_end     (flags[6]),
    .flag_cpb4_end     (flags[7]),
    .busy              (busy),
    .out_current_state (cur_state),
    .out_prev_state    (prev_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_prev  = 0;
    m_pend  = 0;
  endtask

  task automatic model_step();
    int nxt;
    nxt = m_phase;
    if (!reset) begin
      model_reset();
      return;
    end
    if (man_reset) begin
      nxt    = 0;
      m_pend = 0;
    end else if (m_phase == 0) begin
      if (start || m_pend) begin
        nxt    = 1;
        m_pend = 0;
      end
    end else begin
      if (start) m_pend = 1;
      if (flags[m_phase]) nxt = (m_phase == 7) ? (auto ? 1 : 0) : m_phase + 1;
    end
    if (nxt != m_phase) m_prev = m_phase;
    m_phase = nxt;
  endtask

  // Advance one clock, update the model with the inputs seen at that edge, check #1 later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("state", int'(cur_state), m_phase);
    check("prev", int'(prev_state), m_prev);
    check("busy", int'(busy), int'(m_phase != 0));
    if (busy) busy_cycles++;
    else busy_drops++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Wait 10 cycles in the current phase (counting the entry sample), then pulse its flag.
  task automatic finish_phase(input int ph, input int exp_next);
    repeat (9) cycle();
    flags[ph] = 1'b1;
    cycle();
    flags = '0;
    check($sformatf("advance_from_%0d", ph), int'(cur_state), exp_next);
  endtask

  initial begin
    // Reset, then idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", int'(cur_state), 0);
    check("rst_prev", int'(prev_state), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b1;
    repeat (5) cycle();
    check("idle_state", int'(cur_state), 0);

    // Full run, auto=0
    busy_cycles = 0;
    pulse_start();
    check("start_to_first_load", int'(cur_state), 1);
    for (int p = 1; p <= 7; p++) finish_phase(p, (p == 7) ? 0 : p + 1);
    check("run_busy_cycles", busy_cycles, 70);
    check("run_prev_after_idle", int'(prev_state), 7);
    check("run_busy_end", int'(busy), 0);
    cycle();

    // Auto chain
    auto = 1'b1;
    pulse_start();
    busy_drops = 0;
    for (int p = 1; p <= 7; p++) finish_phase(p, (p == 7) ? 1 : p + 1);
    check("auto_prev", int'(prev_state), 7);
    check("auto_busy_drops", busy_drops, 0);
    auto = 1'b0;
    man_reset = 1'b1;
    cycle();
    man_reset = 1'b0;
    cycle();

    // Start mid-run
    pulse_start();
    for (int p = 1; p <= 3; p++) finish_phase(p, p + 1);
    pulse_start();
    check("midrun_start_no_effect", int'(cur_state), 4);
    for (int p = 4; p <= 7; p++) finish_phase(p, (p == 7) ? 0 : p + 1);
    cycle();
    check("pending_relaunch", int'(cur_state), 1);
    cycle();
    check("pending_cleared_hold", int'(cur_state), 1);

    // Abort in CPB_LOADNEW with simultaneous start
    for (int p = 1; p <= 4; p++) finish_phase(p, p + 1);
    man_reset = 1'b1;
    start = 1'b1;
    cycle();
    man_reset = 1'b0;
    start = 1'b0;
    check("abort_state", int'(cur_state), 0);
    check("abort_prev", int'(prev_state), 5);
    check("abort_busy", int'(busy), 0);
    repeat (3) cycle();
    check("abort_no_pending", int'(cur_state), 0);

    // Stray flag, then asynchronous reset mid-CPB_1
    pulse_start();
    finish_phase(1, 2);
    flags[6] = 1'b1;
    cycle();
    flags = '0;
    check("stray_flag_hold", int'(cur_state), 2);
    finish_phase(2, 3);
    cycle();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rst_state", int'(cur_state), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_prev", int'(prev_state), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      if (i % 64 == 0) auto = 1'($urandom_range(0, 1));
      start     = ($urandom_range(0, 9) == 0);
      man_reset = ($urandom_range(0, 59) == 0);
      for (int p = 1; p <= 7; p++) flags[p] = ($urandom_range(0, 3) == 0);
      cycle();
    end
    start = 1'b0;
    man_reset = 1'b0;
    flags = '0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

endmodule
